// File: rtl/posit_decode_arbiter.sv
// posit_decode_arbiter
//   Shares a single combinational posit decoder between NREQ requesters.
//   A round-robin arbiter picks one valid requester per cycle. Its operand is
//   decoded into sign/regime/exponent/mantissa and captured in one output
//   register stage, tagged with the winning requester index.
//
// Ports
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   req_valid      per-requester operand valid
//   req_posit      packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_ready      one-hot grant (zero while the output stage cannot accept)
//   out_valid      output register holds a decoded result
//   out_ready      downstream accepts the result
//   out_id         requester index that produced the result
//   out_sign       0 = POS, 1 = NEG
//   out_regime     signed regime (two's complement)
//   out_exponent   exponent bits, right aligned
//   out_mantissa   {1'b1, fraction}, MSB aligned
//   out_zero       operand was zero
//   out_nar        operand was NaR
module posit_decode_arbiter #(
    parameter int WIDTH = 8,
    parameter int EN    = 1,
    parameter int NREQ  = 4,
    parameter int W_REG = $clog2(WIDTH) + 1,
    parameter int W_EXP = $clog2(WIDTH) + 1,
    parameter int W_MAN = WIDTH,
    parameter int W_ID  = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_posit,
    output logic [NREQ-1:0]         req_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [W_ID-1:0]         out_id,
    output logic                    out_sign,
    output logic [W_REG-1:0]        out_regime,
    output logic [W_EXP-1:0]        out_exponent,
    output logic [W_MAN-1:0]        out_mantissa,
    output logic                    out_zero,
    output logic                    out_nar
);

    if (NREQ < 2 || WIDTH < 4 || W_MAN != WIDTH || EN < 1 || EN > WIDTH - 1) begin : g_param_check
        $error("posit_decode_arbiter: unsupported parameters (need NREQ>=2, WIDTH>=4)");
    end

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t                 state_r;
    state_t                 state_next_s;
    logic [W_ID-1:0]        rr_ptr_r;
    logic [W_ID-1:0]        win_id_s;
    logic                   win_found_s;
    logic [W_ID:0]          cand_s;
    logic                   accept_s;
    logic                   transfer_s;

    logic [WIDTH-1:0]       dec_posit_s;
    logic [WIDTH-2:0]       body_s;
    logic [WIDTH-2:0]       rest_s;
    logic [WIDTH-2:0]       frac_s;
    logic [W_REG-1:0]       run_s;
    logic                   run_done_s;
    logic                   first_s;
    logic                   dec_sign_s;
    logic [W_REG-1:0]       dec_regime_s;
    logic [W_EXP-1:0]       dec_exp_s;
    logic [W_MAN-1:0]       dec_man_s;
    logic                   dec_zero_s;
    logic                   dec_nar_s;

    assign accept_s   = ~out_valid | out_ready;
    assign transfer_s = win_found_s & accept_s;

    // Round-robin search starting at rr_ptr, wrapping modulo NREQ.
    always_comb begin
        win_found_s = 1'b0;
        win_id_s    = '0;
        cand_s      = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand_s = {1'b0, rr_ptr_r} + (W_ID+1)'(i);
            if (cand_s >= (W_ID+1)'(NREQ)) begin
                cand_s = cand_s - (W_ID+1)'(NREQ);
            end else begin
                cand_s = cand_s;
            end
            if (!win_found_s && req_valid[cand_s[W_ID-1:0]]) begin
                win_found_s = 1'b1;
                win_id_s    = cand_s[W_ID-1:0];
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Grant: one-hot winner, suppressed under backpressure and during reset.
    always_comb begin
        if (win_found_s && accept_s && rst_n) begin
            req_ready = NREQ'(1) << win_id_s;
        end else begin
            req_ready = '0;
        end
    end

    assign dec_posit_s = req_posit[win_id_s*WIDTH +: WIDTH];

    // Posit decoder: negative operands are decoded from their two's complement.
    always_comb begin
        dec_zero_s = (dec_posit_s == '0);
        dec_nar_s  = (dec_posit_s == {1'b1, {(WIDTH-1){1'b0}}});
        body_s     = dec_posit_s[WIDTH-1] ? (~dec_posit_s[WIDTH-2:0] + (WIDTH-1)'(1))
                                          : dec_posit_s[WIDTH-2:0];
        first_s    = body_s[WIDTH-2];
        run_s      = '0;
        run_done_s = 1'b0;
        for (int i = WIDTH - 2; i >= 0; i--) begin
            if (!run_done_s && (body_s[i] == first_s)) begin
                run_s = run_s + W_REG'(1);
            end else begin
                run_done_s = 1'b1;
            end
        end
        // Drop the regime run and its terminating bit; exponent follows at the top.
        rest_s    = body_s << (run_s + W_REG'(1));
        dec_exp_s = '0;
        for (int j = 0; j < EN; j++) begin
            dec_exp_s = {dec_exp_s[W_EXP-2:0], rest_s[WIDTH-2-j]};
        end
        frac_s = rest_s << EN;
        if (dec_zero_s || dec_nar_s) begin
            dec_sign_s   = dec_nar_s;
            dec_regime_s = '0;
            dec_exp_s    = '0;
            dec_man_s    = '0;
        end else begin
            dec_sign_s   = dec_posit_s[WIDTH-1];
            dec_regime_s = first_s ? (run_s - W_REG'(1)) : (W_REG'(0) - run_s);
            dec_man_s    = {1'b1, frac_s};
        end
    end

    // Output stage state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= EMPTY;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Output stage next state: fill on transfer, drain when accepted downstream.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            EMPTY: begin
                if (transfer_s) state_next_s = FULL;
                else            state_next_s = EMPTY;
            end
            FULL: begin
                if (transfer_s)     state_next_s = FULL;
                else if (out_ready) state_next_s = EMPTY;
                else                state_next_s = FULL;
            end
            default: state_next_s = EMPTY;
        endcase
    end

    // Output stage flags derived from the state register.
    always_comb begin
        out_valid = (state_r == FULL);
    end

    // Result capture and round-robin pointer advance on each transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r     <= '0;
            out_id       <= '0;
            out_sign     <= 1'b0;
            out_regime   <= '0;
            out_exponent <= '0;
            out_mantissa <= '0;
            out_zero     <= 1'b0;
            out_nar      <= 1'b0;
        end else if (transfer_s) begin
            rr_ptr_r     <= (win_id_s == W_ID'(NREQ - 1)) ? '0 : (win_id_s + W_ID'(1));
            out_id       <= win_id_s;
            out_sign     <= dec_sign_s;
            out_regime   <= dec_regime_s;
            out_exponent <= dec_exp_s;
            out_mantissa <= dec_man_s;
            out_zero     <= dec_zero_s;
            out_nar      <= dec_nar_s;
        end else begin
            rr_ptr_r     <= rr_ptr_r;
        end
    end

endmodule

// File: tb/tb_posit_decode_arbiter.sv
module tb_posit_decode_arbiter;
    localparam int WIDTH = 8;
    localparam int EN    = 1;
    localparam int NREQ  = 4;
    localparam int W_REG = 4;
    localparam int W_EXP = 4;
    localparam int W_MAN = 8;
    localparam int W_ID  = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_posit;
    logic [NREQ-1:0]       req_ready;
    logic                  out_valid;
    logic                  out_ready;
    logic [W_ID-1:0]       out_id;
    logic                  out_sign;
    logic [W_REG-1:0]      out_regime;
    logic [W_EXP-1:0]      out_exponent;
    logic [W_MAN-1:0]      out_mantissa;
    logic                  out_zero;
    logic                  out_nar;

    posit_decode_arbiter #(.WIDTH(WIDTH), .EN(EN), .NREQ(NREQ)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_posit(req_posit), .req_ready(req_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
        .out_sign(out_sign), .out_regime(out_regime), .out_exponent(out_exponent),
        .out_mantissa(out_mantissa), .out_zero(out_zero), .out_nar(out_nar)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int         m_rr;
    logic       m_valid;
    logic [1:0] m_id;
    logic       m_sign;
    logic [3:0] m_reg;
    logic [3:0] m_exp;
    logic [7:0] m_man;
    logic       m_zero;
    logic       m_nar;
    logic [3:0] exp_ready;
    logic [3:0] act_ready;
    logic [21:0] dut_vec;

    assign dut_vec = {out_valid, out_id, out_sign, out_regime, out_exponent,
                      out_mantissa, out_zero, out_nar};

    function automatic logic [21:0] model_vec();
        return {m_valid, m_id, m_sign, m_reg, m_exp, m_man, m_zero, m_nar};
    endfunction

    // Decode by walking the bit string: regime run, terminator, exponent, fraction.
    function automatic void ref_decode(input logic [7:0] p, output logic s,
                                       output logic [3:0] rg, output logic [3:0] ex,
                                       output logic [7:0] mn, output logic z, output logic n);
        bit         q[$];
        logic [7:0] a;
        bit         r0;
        int         k;
        int         e;
        int         m;
        s = 1'b0; rg = 4'd0; ex = 4'd0; mn = 8'd0; z = 1'b0; n = 1'b0;
        if (p == 8'h00) begin
            z = 1'b1;
        end else if (p == 8'h80) begin
            n = 1'b1;
            s = 1'b1;
        end else begin
            s = p[7];
            a = s ? -p : p;
            for (int i = 6; i >= 0; i--) q.push_back(a[i]);
            r0 = q[0];
            k = 0;
            while (q.size() > 0 && q[0] == r0) begin
                void'(q.pop_front());
                k++;
            end
            if (q.size() > 0) void'(q.pop_front());
            rg = r0 ? 4'(k - 1) : 4'(-k);
            e = 0;
            for (int j = 0; j < EN; j++) begin
                e = e * 2;
                if (q.size() > 0) e = e + int'(q.pop_front());
            end
            ex = 4'(e);
            m = 1;
            for (int j = 0; j < 7; j++) begin
                m = m * 2;
                if (q.size() > 0) m = m + int'(q.pop_front());
            end
            mn = 8'(m);
        end
    endfunction

    function automatic int model_winner(input logic [3:0] v);
        for (int i = 0; i < NREQ; i++) begin
            if (v[(m_rr + i) % NREQ]) return (m_rr + i) % NREQ;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_rr = 0; m_valid = 1'b0; m_id = 2'd0; m_sign = 1'b0; m_reg = 4'd0;
        m_exp = 4'd0; m_man = 8'd0; m_zero = 1'b0; m_nar = 1'b0;
    endtask

    function automatic logic [7:0] rand_posit();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 8'h00;
        if (r == 1) return 8'h80;
        return 8'($urandom_range(0, 255));
    endfunction

    // One clock: drive inputs at the falling edge, record ready, advance model at the rising edge.
    task automatic drive_step(input logic [3:0] v, input logic [31:0] p, input logic ordy);
        int w;
        @(negedge clk);
        req_valid = v;
        req_posit = p;
        out_ready = ordy;
        #1;
        w = model_winner(v);
        exp_ready = (w >= 0 && (!m_valid || ordy)) ? 4'(1 << w) : 4'b0000;
        act_ready = req_ready;
        @(posedge clk);
        if (exp_ready != 4'b0000) begin
            ref_decode(p[w*8 +: 8], m_sign, m_reg, m_exp, m_man, m_zero, m_nar);
            m_id    = 2'(w);
            m_valid = 1'b1;
            m_rr    = (w + 1) % NREQ;
        end else if (ordy) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = 4'b0000;
        model_reset();
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 4'hF;
        req_posit = 32'h1122_3344;
        out_ready = 1'b1;
        model_reset();
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++; $display("FAIL reset_ready: got %b want 0000", req_ready);
        end
        checks++;
        if (dut_vec !== model_vec()) begin
            errors++; $display("FAIL reset_outputs: got %h want %h", dut_vec, model_vec());
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL release_ready: got %b want 0001", req_ready);
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_single();
        logic [7:0] ops [3] = '{8'h40, 8'h50, 8'h20};
        logic [3:0] regs [3] = '{4'h0, 4'h0, 4'hF};
        logic [3:0] exps [3] = '{4'h0, 4'h1, 4'h0};
        for (int i = 0; i < 3; i++) begin
            drive_step(4'b0100, {8'h00, ops[i], 16'h0000}, 1'b1);
            checks++;
            if (act_ready !== 4'b0100 || act_ready !== exp_ready) begin
                errors++; $display("FAIL single_ready[%0d]: got %b want 0100", i, act_ready);
            end
            checks++;
            if (out_valid !== 1'b1 || out_id !== 2'd2 || out_sign !== 1'b0 ||
                out_regime !== regs[i] || out_exponent !== exps[i] || out_mantissa !== 8'h80) begin
                errors++; $display("FAIL single_fields[%0d]: got %h want v1 id2 reg%h exp%h man80",
                                   i, dut_vec, regs[i], exps[i]);
            end
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++; $display("FAIL single_model[%0d]: got %h want %h", i, dut_vec, model_vec());
            end
        end
        drive_step(4'b0000, 32'h0, 1'b1);
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive_step(4'hF, $urandom(), 1'b1);
            checks++;
            if (act_ready !== 4'(1 << (i % 4))) begin
                errors++; $display("FAIL rr_grant[%0d]: got %b want %b", i, act_ready, 4'(1 << (i % 4)));
            end
            checks++;
            if (out_id !== 2'(i % 4) || dut_vec !== model_vec()) begin
                errors++; $display("FAIL rr_out[%0d]: got %h want %h", i, dut_vec, model_vec());
            end
        end
        drive_step(4'b0000, 32'h0, 1'b1);
    endtask

    task automatic test_backpressure();
        drive_step(4'b0001, {24'h0, rand_posit()}, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive_step(4'b0010, {16'h0, 8'h5A, 8'h00}, 1'b0);
            checks++;
            if (act_ready !== 4'b0000) begin
                errors++; $display("FAIL bp_ready[%0d]: got %b want 0000", i, act_ready);
            end
            checks++;
            if (out_valid !== 1'b1 || out_id !== 2'd0 || dut_vec !== model_vec()) begin
                errors++; $display("FAIL bp_hold[%0d]: got %h want %h", i, dut_vec, model_vec());
            end
        end
        drive_step(4'b0010, {16'h0, 8'h5A, 8'h00}, 1'b1);
        checks++;
        if (act_ready !== 4'b0010) begin
            errors++; $display("FAIL bp_release_ready: got %b want 0010", act_ready);
        end
        checks++;
        if (out_id !== 2'd1 || out_valid !== 1'b1 || dut_vec !== model_vec()) begin
            errors++; $display("FAIL bp_release_out: got %h want %h", dut_vec, model_vec());
        end
    endtask

    task automatic test_specials();
        drive_step(4'b0001, 32'h0000_0000, 1'b1);
        checks++;
        if (out_zero !== 1'b1 || out_nar !== 1'b0 || out_sign !== 1'b0 || out_regime !== 4'h0 ||
            out_exponent !== 4'h0 || out_mantissa !== 8'h00 || dut_vec !== model_vec()) begin
            errors++; $display("FAIL special_zero: got %h want %h", dut_vec, model_vec());
        end
        drive_step(4'b0001, 32'h0000_0080, 1'b1);
        checks++;
        if (out_nar !== 1'b1 || out_zero !== 1'b0 || out_sign !== 1'b1 || out_regime !== 4'h0 ||
            out_exponent !== 4'h0 || out_mantissa !== 8'h00 || dut_vec !== model_vec()) begin
            errors++; $display("FAIL special_nar: got %h want %h", dut_vec, model_vec());
        end
        drive_step(4'b0001, 32'h0000_00C0, 1'b1);
        checks++;
        if (out_sign !== 1'b1 || out_mantissa !== 8'h80 || dut_vec !== model_vec()) begin
            errors++; $display("FAIL special_neg: got %h want %h", dut_vec, model_vec());
        end
    endtask

    task automatic test_random();
        logic [7:0] pend [NREQ];
        logic [3:0] v;
        int         bad_ready;
        int         bad_out;
        bad_ready = 0;
        bad_out   = 0;
        for (int i = 0; i < NREQ; i++) pend[i] = rand_posit();
        for (int n = 0; n < 400; n++) begin
            v = 4'($urandom_range(0, 15));
            drive_step(v, {pend[3], pend[2], pend[1], pend[0]}, ($urandom_range(0, 3) != 0));
            checks++;
            if (act_ready !== exp_ready) begin
                errors++; bad_ready++;
                if (bad_ready < 5) $display("FAIL rand_ready[%0d]: got %b want %b", n, act_ready, exp_ready);
            end
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++; bad_out++;
                if (bad_out < 5) $display("FAIL rand_out[%0d]: got %h want %h", n, dut_vec, model_vec());
            end
            for (int i = 0; i < NREQ; i++) begin
                if (exp_ready[i]) pend[i] = rand_posit();
            end
        end
        drive_step(4'b0000, 32'h0, 1'b1);
    endtask

    task automatic test_async_reset();
        drive_step(4'b0001, 32'h0000_0040, 1'b1);
        drive_step(4'b0000, 32'h0, 1'b0);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL areset_pre: got out_valid=%b want 1", out_valid);
        end
        @(negedge clk);
        req_valid = 4'b1000;
        req_posit = 32'h5000_0000;
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (out_valid !== 1'b0 || req_ready !== 4'b0000) begin
            errors++; $display("FAIL areset_mid: got valid=%b ready=%b want 0/0000", out_valid, req_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive_step(4'b1000, 32'h5000_0000, 1'b0);
        checks++;
        if (act_ready !== 4'b1000 || act_ready !== exp_ready) begin
            errors++; $display("FAIL areset_grant: got %b want 1000", act_ready);
        end
        checks++;
        if (out_id !== 2'd3 || out_exponent !== 4'h1 || dut_vec !== model_vec()) begin
            errors++; $display("FAIL areset_out: got %h want %h", dut_vec, model_vec());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_specials();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
